// File: rtl/monster_collider.sv
// Per-monster collider: sweeps the stage wall ROM for blocked directions and
// tracks the weapon attack window. Optional ARENA_BOUND_EN adds fixed arena limits.
module monster_collider #(
  parameter int NUM_WALLS       = 8,
  parameter int AW              = 3,
  parameter int MON_SIZE        = 16,
  parameter int WPN_SIZE        = 16,
  parameter int ATTACK_CYCLES   = 16,
  parameter int COOLDOWN_CYCLES = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [3:0]    i_stagestate,
  input  logic [9:0]    i_mon_h,
  input  logic [9:0]    i_mon_v,
  input  logic [9:0]    i_wpn_h,
  input  logic [9:0]    i_wpn_v,
  input  logic          i_attack,
  input  logic          i_gameover,
  output logic [3+AW:0] o_wall_addr,
  input  logic [39:0]   i_wall_data,
  output logic [3:0]    o_wall_collision,
  output logic          o_weapon_collision,
  output logic          o_enable_weapon_collision,
  output logic          o_scan_done,
  output logic          o_attack_busy
);
  localparam logic [1:0]  S_LOAD = 2'd0, S_SCAN = 2'd1, S_PUB = 2'd2;
  localparam logic [1:0]  A_IDLE = 2'd0, A_ACT = 2'd1, A_COOL = 2'd2;
  localparam int          CMAX = (ATTACK_CYCLES > COOLDOWN_CYCLES) ? ATTACK_CYCLES : COOLDOWN_CYCLES;
  localparam int          CW = $clog2(CMAX);
  localparam logic [CW-1:0] ATK_INIT  = CW'(ATTACK_CYCLES - 1);
  localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [AW:0] LAST = (AW+1)'(NUM_WALLS);
  localparam logic [10:0] MS1 = 11'(MON_SIZE - 1);
  localparam logic [10:0] WS1 = 11'(WPN_SIZE - 1);

  // Inclusive 1-D interval overlap: [lo,hi] vs [a,b].
  function automatic logic ovl(input logic [10:0] lo, input logic [10:0] hi,
                               input logic [10:0] a, input logic [10:0] b);
    return (lo <= b) && (hi >= a);
  endfunction

  logic [1:0]    r_sst;
  logic [3:0]    r_stage;
  logic [3+AW:0] r_addr;
  logic [AW:0]   r_cnt;
  logic [9:0]    r_mh, r_mv;
  logic [3:0]    r_acc, r_wc;
  logic          r_done;
  logic [1:0]    r_ast;
  logic [CW-1:0] r_acnt;
  logic          r_wcol;

  logic [10:0] w_h0, w_v0, w_h1, w_v1, w_hx0, w_hx1, w_vy0, w_vy1;
  logic        w_empty, w_hc, w_vc;
  logic [3:0]  w_hit, w_arena;
  logic        w_wpn_hit;

  assign w_h0  = {1'b0, i_wall_data[39:30]};
  assign w_v0  = {1'b0, i_wall_data[29:20]};
  assign w_h1  = {1'b0, i_wall_data[19:10]};
  assign w_v1  = {1'b0, i_wall_data[9:0]};
  assign w_hx0 = {1'b0, r_mh};
  assign w_hx1 = w_hx0 + MS1;
  assign w_vy0 = {1'b0, r_mv};
  assign w_vy1 = w_vy0 + MS1;

  // A -1 shift of the box is tested as a +1 shift of the wall, avoiding underflow at 0.
  always_comb begin
    w_empty = (w_h0 > w_h1) || (w_v0 > w_v1);
    w_hc    = ovl(w_hx0, w_hx1, w_h0, w_h1);
    w_vc    = ovl(w_vy0, w_vy1, w_v0, w_v1);
    w_hit   = 4'b0000;
    if (!w_empty) begin
      w_hit[0] = ovl(w_hx0, w_hx1, w_h0 + 11'd1, w_h1 + 11'd1) && w_vc;
      w_hit[1] = ovl(w_hx0 + 11'd1, w_hx1 + 11'd1, w_h0, w_h1) && w_vc;
      w_hit[2] = w_hc && ovl(w_vy0 + 11'd1, w_vy1 + 11'd1, w_v0, w_v1);
      w_hit[3] = w_hc && ovl(w_vy0, w_vy1, w_v0 + 11'd1, w_v1 + 11'd1);
    end
  end

`ifdef ARENA_BOUND_EN
  assign w_arena = {r_mv <= 10'd20, r_mv >= 10'd220, r_mh >= 10'd300, r_mh <= 10'd20};
`else
  assign w_arena = 4'b0000;
`endif

  assign w_wpn_hit = ovl({1'b0, i_mon_h}, {1'b0, i_mon_h} + MS1, {1'b0, i_wpn_h}, {1'b0, i_wpn_h} + WS1)
                  && ovl({1'b0, i_mon_v}, {1'b0, i_mon_v} + MS1, {1'b0, i_wpn_v}, {1'b0, i_wpn_v} + WS1);

  // Stage is latched on entry to LOAD so the address shown in LOAD already matches it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sst   <= S_LOAD;
      r_stage <= 4'd0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_mh    <= 10'd0;
      r_mv    <= 10'd0;
      r_acc   <= 4'd0;
      r_wc    <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_sst)
        S_LOAD: begin
          if (i_stagestate != r_stage) begin
            r_stage <= i_stagestate;
            r_addr  <= {i_stagestate, {AW{1'b0}}};
          end else begin
            r_mh   <= i_mon_h;
            r_mv   <= i_mon_v;
            r_acc  <= 4'd0;
            r_cnt  <= (AW+1)'(1);
            r_addr <= {r_stage, AW'(1)};
            r_sst  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (i_stagestate != r_stage) begin
            r_stage <= i_stagestate;
            r_addr  <= {i_stagestate, {AW{1'b0}}};
            r_sst   <= S_LOAD;
          end else begin
            r_acc  <= r_acc | w_hit;
            r_cnt  <= r_cnt + (AW+1)'(1);
            r_addr <= {r_stage, r_cnt[AW-1:0] + AW'(1)};
            if (r_cnt == LAST) r_sst <= S_PUB;
          end
        end
        S_PUB: begin
          r_wc    <= r_acc | w_arena;
          r_done  <= 1'b1;
          r_stage <= i_stagestate;
          r_addr  <= {i_stagestate, {AW{1'b0}}};
          r_sst   <= S_LOAD;
        end
        default: r_sst <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ast  <= A_IDLE;
      r_acnt <= '0;
      r_wcol <= 1'b0;
    end else begin
      r_wcol <= w_wpn_hit && !i_gameover;
      if (i_gameover) begin
        r_ast  <= A_IDLE;
        r_acnt <= '0;
      end else begin
        case (r_ast)
          A_IDLE: if (i_attack) begin
            r_ast  <= A_ACT;
            r_acnt <= ATK_INIT;
          end
          A_ACT: if (r_acnt == '0) begin
            r_ast  <= A_COOL;
            r_acnt <= COOL_INIT;
          end else r_acnt <= r_acnt - CW'(1);
          A_COOL: if (r_acnt == '0) r_ast <= A_IDLE;
                  else r_acnt <= r_acnt - CW'(1);
          default: r_ast <= A_IDLE;
        endcase
      end
    end
  end

  assign o_wall_addr               = r_addr;
  assign o_wall_collision          = r_wc;
  assign o_scan_done               = r_done;
  assign o_weapon_collision        = r_wcol;
  assign o_enable_weapon_collision = (r_ast == A_ACT);
  assign o_attack_busy             = (r_ast != A_IDLE);
endmodule

// File: doc/monster_collider.md
Name: monster_collider

Overview:
- Producer side of the monster collision interface.
- Generates wall_collision[3:0], weapon_collision and enable_weapon_collision for one monster instance, from:
  - the monster's reported position,
  - the player weapon position and attack button,
  - a per-stage wall-rectangle ROM it sweeps continuously.
- Sits between the stage/player logic and the monster instance; one collider per monster.

Parameters:
- NUM_WALLS, 8, wall entries per stage (power of 2).
- AW, 3, log2(NUM_WALLS).
- MON_SIZE, 16, monster sprite edge in pixels.
- WPN_SIZE, 16, weapon hitbox edge in pixels.
- ATTACK_CYCLES, 16, clk cycles the weapon stays live per attack.
- COOLDOWN_CYCLES, 32, clk cycles after a swing during which attack is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stagestate  in  4  current stage, selects wall set
- mon_h  in  10  monster top-left x
- mon_v  in  10  monster top-left y
- wpn_h  in  10  weapon top-left x
- wpn_v  in  10  weapon top-left y
- attack  in  1  attack request, level
- gameover  in  1  game ended
- wall_addr  out  4+AW  ROM address {stagestate, index}
- wall_data  in  40  {h0,v0,h1,v1}, 10 b each, inclusive corners; valid the cycle after wall_addr
- wall_collision  out  4  [0]=left, [1]=right, [2]=down, [3]=up blocked
- weapon_collision  out  1  weapon box overlaps monster box
- enable_weapon_collision  out  1  weapon live
- scan_done  out  1  1-cycle pulse when wall_collision is updated
- attack_busy  out  1  attack FSM not idle

Behaviour:
- Reset: wall_collision=0, weapon_collision=0, enable_weapon_collision=0, scan_done=0, attack_busy=0, wall_addr=0; sweep FSM in LOAD, attack FSM in IDLE.
- Boxes are inclusive:
  - monster box: [mon_h, mon_h+MON_SIZE-1] x [mon_v, mon_v+MON_SIZE-1];
  - weapon box: same construction using wpn_h/wpn_v and WPN_SIZE.
  - All arithmetic is 11 bit, so there is no wrap.
- Sweep FSM:
  - LOAD (1 cycle): snapshot mon_h, mon_v, stagestate; wall_addr={stage,0}; clear accumulators.
  - SCAN, cycles j=1..NUM_WALLS: wall_data is entry j-1. Test the monster box shifted by (-1,0), (+1,0), (0,+1), (0,-1) against the entry and OR each result into accumulator bits 0..3. wall_addr={stage,j}; the value is don't-care when j=NUM_WALLS.
  - PUB (1 cycle): wall_collision<=accum, scan_done=1, then LOAD.
  - Period and latency: NUM_WALLS+2 cycles from snapshot to publish.
- Entries with h0>h1 or v0>v1 are empty and never collide.
- stagestate differing from its snapshot during SCAN: abort; the next cycle is LOAD. wall_collision holds and there is no scan_done.
- wall_collision changes only in PUB and holds between publishes.
- Attack FSM:
  - IDLE: attack=1 -> ACTIVE with counter=ATTACK_CYCLES-1.
  - ACTIVE: enable_weapon_collision=1; decrement; at 0 -> COOL with counter=COOLDOWN_CYCLES-1.
  - COOL: attack ignored; at 0 -> IDLE.
  - attack_busy=1 in ACTIVE and COOL.
  - Holding attack high re-triggers only after COOL has expired.
- weapon_collision is registered every cycle from the live box overlap (1-cycle latency) and is independent of the FSM state.
- gameover=1 (synchronous, checked each cycle):
  - attack FSM forced to IDLE;
  - enable_weapon_collision=0, weapon_collision=0;
  - wall sweep keeps running.
- Reset asserted mid-sweep or mid-attack returns everything to the reset values on the next edge.

Optional Feature:
- ARENA_BOUND_EN defined:
  - PUB additionally ORs arena limits into wall_collision: bit1 if mon_h>=300, bit0 if mon_h<=20, bit2 if mon_v>=220, bit3 if mon_v<=20.
  - Limits use the snapshot position.
- Undefined: wall_collision reflects ROM walls only.

Test Plan:
- Single-wall right block: stage 0, entry0=(100,100,119,139), all other entries empty, mon=(84,110) -> wall_collision=4'b0010 with scan_done 10 cycles after LOAD.
- Up block: entry0=(100,80,119,93), mon=(100,94) -> 4'b1000. Move mon to (100,96) -> 4'b0000 on the next publish.
- Stage switch mid-SCAN at cycle 4: no scan_done on that sweep; wall_addr upper bits follow the new stage from the next LOAD; old wall_collision held.
- Attack pulse at t0:
  - enable_weapon_collision high for 16 cycles;
  - attack held high is ignored for the following 32 cycles;
  - re-enable at t0+49.
- Weapon overlap: wpn=(90,110), mon=(84,110) -> weapon_collision=1 one cycle later. wpn=(100,110) -> 0. Assert gameover during ACTIVE -> enable and weapon_collision 0 on the next cycle.
- With ARENA_BOUND_EN defined, mon=(300,20), no walls -> wall_collision=4'b1010; without the macro -> 4'b0000.
